wlmont_iter_ctrl: RTL and testbench

// Iterative scheduler for word-level (WL) Montgomery reduction.

---
 rtl/wlmont_iter_ctrl_pkg.sv | 20 ++
 rtl/wlmont_iter_ctrl_if.sv | 25 ++
 rtl/wlmont_iter_ctrl_sub_p0.sv | 56 +++++
 rtl/wlmont_iter_ctrl.sv | 144 ++++++++++++++
 tb/tb_wlmont_iter_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wlmont_iter_ctrl_pkg.sv
// Shared definitions for the word-level Montgomery iterative controller:
// iteration/latency helpers and the controller state encoding.
package wlmont_pkg;

  function automatic int wl_iters(input int logq, input int w);
    return (logq + w - 1) / w;
  endfunction

  function automatic int stage_lat(input int mullat);
    return mullat + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } wlmont_ctrl_state_e;

endpackage

// File: rtl/wlmont_iter_ctrl_if.sv
// Valid/ready operand and result channels of the iterative Montgomery controller.
interface wlmont_iter_ctrl_if #(
  parameter int LOGQ = 31,
  parameter int LOGT = 62,
  parameter int TAGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [LOGT-1:0] in_data;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] out_data;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/wlmont_iter_ctrl_sub_p0.sv
// One word-level Montgomery step for q = qH*2^W + 1: To = (Ti + m*q) / 2^W with
// m = -Ti mod 2^W, which simplifies to TH + m*qH + (TL != 0).
module wlmont_sub_p0 #(
  parameter int LOGQ   = 31,
  parameter int W      = 16,
  parameter int LOGTI  = 62,
  parameter int LOGTO  = 62,
  parameter int MULLAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LOGQ-W-1:0] qH_i,
  input  logic [LOGTI-1:0]  ti_i,
  output logic [LOGTO-1:0]  to_o
);
  localparam int THW = LOGTI - W;

  logic [W-1:0]    tl_s;
  logic [THW-1:0]  th_s;
  logic [W-1:0]    m_s;
  logic            cy_s;
  logic [LOGQ-1:0] prod_s;

  logic [LOGQ-1:0] prod_q [MULLAT];
  logic [THW-1:0]  th_q   [MULLAT];
  logic            cy_q   [MULLAT];

  assign tl_s   = ti_i[W-1:0];
  assign th_s   = ti_i[LOGTI-1:W];
  assign m_s    = ~tl_s + W'(1);
  assign cy_s   = |tl_s;
  assign prod_s = LOGQ'(m_s) * LOGQ'(qH_i);

  // Multiply pipeline; the final add is combinational and captured by the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MULLAT; i++) begin
        prod_q[i] <= '0;
        th_q[i]   <= '0;
        cy_q[i]   <= 1'b0;
      end
    end else begin
      prod_q[0] <= prod_s;
      th_q[0]   <= th_s;
      cy_q[0]   <= cy_s;
      for (int i = 1; i < MULLAT; i++) begin
        prod_q[i] <= prod_q[i-1];
        th_q[i]   <= th_q[i-1];
        cy_q[i]   <= cy_q[i-1];
      end
    end
  end

  assign to_o = LOGTO'(th_q[MULLAT-1]) + LOGTO'(prod_q[MULLAT-1]) + LOGTO'(cy_q[MULLAT-1]);

endmodule

// File: rtl/wlmont_iter_ctrl.sv
// Iterative word-level Montgomery reduction: one shared stage reused for L
// iterations, then a single conditional subtraction of the latched q.
module wlmont_iter_ctrl
  import wlmont_pkg::*;
#(
  parameter int LOGQ   = 31,
  parameter int W      = 16,
  parameter int LOGT   = 62,
  parameter int MULLAT = 1,
  parameter int TAGW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LOGQ-1:0]   cfg_q_i,
  input  logic [LOGQ-W-1:0] cfg_qH_i,
  output logic              busy_o,
  wlmont_iter_ctrl_if.slave bus
);
  localparam int L    = wl_iters(LOGQ, W);
  localparam int SL   = stage_lat(MULLAT);
  localparam int ITW  = $clog2(L + 1);
  localparam int LATW = $clog2(SL + 1);

  wlmont_ctrl_state_e state_q, state_d;
  logic [ITW-1:0]    it_q, it_d;
  logic [LATW-1:0]   lat_q, lat_d;
  logic [LOGT-1:0]   op_q, op_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [LOGQ-1:0]   cq_q, cq_d;
  logic [LOGQ-W-1:0] cqh_q, cqh_d;
  logic [LOGQ-1:0]   od_q, od_d;
  logic [TAGW-1:0]   ot_q, ot_d;

  logic [LOGT-1:0]   to_s;
  logic [LOGQ-1:0]   diff_s;
  logic              ge_s;

  wlmont_sub_p0 #(
    .LOGQ  (LOGQ),
    .W     (W),
    .LOGTI (LOGT),
    .LOGTO (LOGT),
    .MULLAT(MULLAT)
  ) u_stage (
    .clk (clk),
    .rst (rst),
    .qH_i(cqh_q),
    .ti_i(op_q),
    .to_o(to_s)
  );

  // After L iterations op_q < 2q, so the low LOGQ bits of op_q - q are exact when ge_s.
  assign ge_s   = (op_q >= LOGT'(cq_q));
  assign diff_s = op_q[LOGQ-1:0] - cq_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    it_d    = it_q;
    lat_d   = lat_q;
    op_d    = op_q;
    tag_d   = tag_q;
    cq_d    = cq_q;
    cqh_d   = cqh_q;
    od_d    = od_q;
    ot_d    = ot_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_data;
          tag_d   = bus.in_tag;
          cq_d    = cfg_q_i;
          cqh_d   = cfg_qH_i;
          it_d    = '0;
          lat_d   = '0;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (lat_q == LATW'(SL - 1)) begin
          op_d  = to_s;
          it_d  = it_q + ITW'(1);
          lat_d = '0;
          if (it_q == ITW'(L - 1)) begin
            state_d = FINAL;
          end else begin
            state_d = WAIT;
          end
        end else begin
          lat_d = lat_q + LATW'(1);
        end
      end
      FINAL: begin
        od_d    = ge_s ? diff_s : op_q[LOGQ-1:0];
        ot_d    = tag_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      it_q    <= '0;
      lat_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      cq_q    <= '0;
      cqh_q   <= '0;
      od_q    <= '0;
      ot_q    <= '0;
    end else begin
      state_q <= state_d;
      it_q    <= it_d;
      lat_q   <= lat_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      cq_q    <= cq_d;
      cqh_q   <= cqh_d;
      od_q    <= od_d;
      ot_q    <= ot_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = od_q;
  assign bus.out_tag   = ot_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_wlmont_iter_ctrl.sv
// Scoreboard bench for wlmont_iter_ctrl: the driver pushes expected results at
// each accept, a negedge monitor pops and compares on every output transfer.
module tb_wlmont_iter_ctrl;
  localparam int LOGQ   = 31;
  localparam int W      = 16;
  localparam int LOGT   = 62;
  localparam int MULLAT = 1;
  localparam int TAGW   = 4;
  localparam logic [63:0] Q  = 64'd2013265921;
  localparam logic [63:0] QH = 64'd30720;

  logic clk = 1'b0;
  logic rst;
  logic [LOGQ-1:0]   cfg_q;
  logic [LOGQ-W-1:0] cfg_qh;
  logic busy;

  always #5 clk = ~clk;

  wlmont_iter_ctrl_if #(.LOGQ(LOGQ), .LOGT(LOGT), .TAGW(TAGW)) bus ();

  wlmont_iter_ctrl #(
    .LOGQ(LOGQ), .W(W), .LOGT(LOGT), .MULLAT(MULLAT), .TAGW(TAGW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_q_i (cfg_q),
    .cfg_qH_i(cfg_qh),
    .busy_o  (busy),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int n_in   = 0;
  int n_out  = 0;
  int rdy_mode = 0;
  logic [63:0] exp_data_q [$];
  logic [3:0]  exp_tag_q  [$];

  // Reference: T * 2^-32 mod q by 32 modular halvings.
  function automatic logic [63:0] model(input logic [63:0] t);
    logic [63:0] x;
    x = t % Q;
    for (int i = 0; i < 32; i++) begin
      if (x[0]) x = (x + Q) >> 1;
      else      x = x >> 1;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_ready generator: 0 = low, 1 = high, 2 = random.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a transfer is seen at negedge and completes on the next posedge.
  initial begin
    logic [63:0] d;
    logic [3:0]  t;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_out++;
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0d tag %0d, expected no transfer",
                   bus.out_data, bus.out_tag);
        end else begin
          d = exp_data_q.pop_front();
          t = exp_tag_q.pop_front();
          chk("out_data", 64'(bus.out_data), d);
          chk("out_tag", 64'(bus.out_tag), 64'(t));
        end
      end
    end
  end

  task automatic send(input logic [63:0] t, input logic [3:0] tag, input logic [63:0] exp);
    int n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = t[LOGT-1:0];
    bus.in_tag   = tag;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.in_ready !== 1'b1 && n < 300);
    if (bus.in_ready !== 1'b1) begin
      chk("accept_timeout", 64'(n), 64'd0);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_data_q.push_back(exp);
      exp_tag_q.push_back(tag);
      n_in++;
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 64'(exp_data_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] t;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_tag   = '0;
    cfg_q        = LOGQ'(Q);
    cfg_qh       = (LOGQ-W)'(QH);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2^32 -> 1 with exact latency, then held in DONE for 10 cycles.
    rdy_mode = 0;
    send(64'h1_0000_0000, 4'd3, 64'd1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.out_valid !== 1'b1 && n < 20);
    chk("latency", 64'(n), 64'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_data", 64'(bus.out_data), 64'd1);
      chk("hold_tag", 64'(bus.out_tag), 64'd3);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    rdy_mode = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid === 1'b1 && bus.out_ready === 1'b1) && n < 20);
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("release_busy", 64'(busy), 64'd0);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);

    // Boundary operands: 0, q, and the largest representable product.
    send(64'd0, 4'd1, 64'd0);
    send(Q, 4'd2, 64'd0);
    t = 64'h3FFF_FFFF_FFFF_FFFF;
    send(t, 4'd4, model(t));
    send(64'h0000_0000_0001_0000, 4'd8, model(64'h0000_0000_0001_0000));
    wait_drain();

    // Garbage cfg after accept must not affect the in-flight operation.
    send(Q, 4'd7, 64'd0);
    cfg_q  = 31'h5A5A_1234;
    cfg_qh = 15'h1357;
    wait_drain();
    cfg_q  = LOGQ'(Q);
    cfg_qh = (LOGQ-W)'(QH);
    send(Q + 64'd5, 4'd9, model(Q + 64'd5));
    cfg_q  = 31'h7FFF_FFFF;
    cfg_qh = 15'h7FFF;
    wait_drain();
    cfg_q  = LOGQ'(Q);
    cfg_qh = (LOGQ-W)'(QH);

    // Reset in WAIT discards the operand and clears the outputs immediately.
    send(64'h1_0000_0000, 4'd5, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_data", 64'(bus.out_data), 64'd0);
    chk("midrst_out_tag", 64'(bus.out_tag), 64'd0);
    void'(exp_data_q.pop_back());
    void'(exp_tag_q.pop_back());
    n_in--;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    send(64'h1_0000_0000, 4'd6, 64'd1);
    wait_drain();

    // Random traffic with random gaps and back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      t = {$urandom, $urandom};
      t[63:62] = 2'b00;
      send(t, 4'(i), model(t));
    end
    rdy_mode = 1;
    wait_drain();
    repeat (4) @(posedge clk);

    chk("transfer_count", 64'(n_out), 64'(n_in));
    chk("queue_empty", 64'(exp_data_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
